// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the 8-bit Wishbone classic initiator.
//   - FSM state encoding (IDLE / BUS / RESP)
//   - default abort threshold for the optional ACK timeout
//   - response data helper
// No ports.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    // Data returned with a completed cycle: the slave data for reads and
    // zero for writes.
    function automatic logic [7:0] resp_data(input logic we, input logic [7:0] dat);
        logic [7:0] result;
        if (we) begin
            result = 8'h00;
        end else begin
            result = dat;
        end
        return result;
    endfunction

endpackage

// File: rtl/wbm_timeout.sv
// -----------------------------------------------------------------------------
// wbm_timeout
// 8-bit wait counter for the Wishbone initiator. It is cleared when a
// command is accepted and counts every BUS cycle in which no ACK arrives.
// `expired` is high in the cycle whose closing edge would make the count
// reach TIMEOUT, so the FSM can abort on that same edge.
// Ports:
//   clk     in   system clock (rising edge)
//   rst     in   asynchronous active-high reset
//   clr     in   restart the count (command accepted)
//   en      in   BUS cycle without ACK
//   expired out  count reaches TIMEOUT at the coming edge
// -----------------------------------------------------------------------------
module wbm_timeout
    import wb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_d == TIMEOUT);

endmodule

// File: rtl/wb_master8.sv
// -----------------------------------------------------------------------------
// wb_master8
// Single-outstanding 8-bit Wishbone classic initiator. A command accepted on
// the cmd_* handshake becomes one Wishbone cycle; its completion is reported
// as a one-cycle pulse on rsp_valid with rsp_dat/rsp_err held afterwards.
// Optional feature macro: WBM_TIMEOUT_EN -- abort a cycle that receives no
// ACK within TIMEOUT BUS cycles and report it with rsp_err=1.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_we/cmd_adr/cmd_dat    command write flag, address, write data
//   rsp_valid/rsp_dat/rsp_err response pulse, read data, timeout flag
//   WB_ADRo/WB_DATo/WB_WEo    Wishbone address, write data, write enable
//   WB_CYCo/WB_STBo           Wishbone cycle / strobe
//   WB_DATi/WB_ACKi           Wishbone read data / acknowledge
//   busy                      FSM not in IDLE
// -----------------------------------------------------------------------------
module wb_master8
    import wb_pkg::*;
#(
    parameter int         ADDR_W  = 2,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [7:0]        cmd_dat,
    output logic              rsp_valid,
    output logic [7:0]        rsp_dat,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] WB_ADRo,
    output logic [7:0]        WB_DATo,
    input  logic [7:0]        WB_DATi,
    output logic              WB_WEo,
    output logic              WB_CYCo,
    output logic              WB_STBo,
    input  logic              WB_ACKi,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]        dat_q, dat_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              expired_s;

`ifdef WBM_TIMEOUT_EN
    logic accept_s;
    logic bus_wait_s;

    assign accept_s   = (state_q == ST_IDLE) && cmd_valid;
    assign bus_wait_s = (state_q == ST_BUS) && !WB_ACKi;

    wbm_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s),
        .en      (bus_wait_s),
        .expired (expired_s)
    );
`else
    // Without the timeout the BUS state waits for ACK forever.
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign expired_s        = 1'b0;
`endif

    // FSM next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_BUS;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // ACK wins over a timeout expiring on the same edge.
                if (WB_ACKi) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = resp_data(we_q, WB_DATi);
                    rsp_err_d   = 1'b0;
                end else if (expired_s) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 8'h00;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= 8'h00;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign WB_ADRo   = adr_q;
    assign WB_DATo   = dat_q;
    assign WB_WEo    = we_q;
    assign WB_CYCo   = cyc_q;
    assign WB_STBo   = cyc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master8.sv
module tb_wb_master8;

    localparam logic [7:0] TO = 8'd4;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [1:0] cmd_adr;
    logic [7:0] cmd_dat;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_dat;
    logic [1:0] WB_ADRo;
    logic [7:0] WB_DATo, WB_DATi;
    logic       WB_WEo, WB_CYCo, WB_STBo, WB_ACKi;
    logic       busy;

    wb_master8 #(.ADDR_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi),
        .WB_WEo(WB_WEo), .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo),
        .WB_ACKi(WB_ACKi), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc_num = 0;
    always @(posedge clk) cyc_num <= cyc_num + 1;

    typedef struct {
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
        logic [7:0] rdat;
        logic       err;
        int         rsp_cyc;
        int         bus_len;
    } txn_t;

    txn_t rsp_q[$];
    txn_t wb_q[$];
    logic [7:0] model_mem [4];
    logic [7:0] slave_mem [4];

    int n_checks = 0;
    int n_errors = 0;
    int n_rsp = 0;
    int n_wb = 0;
    int ack_delay = 1;
    bit ack_tied = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave: ACK after ack_delay cycles of CYC (or always when tied),
    // random ACK/data noise outside the cycle.
    initial begin
        int slv_cnt;
        slv_cnt = 0;
        WB_ACKi = 1'b0;
        WB_DATi = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_cnt = 0;
                WB_ACKi = 1'b0;
            end else if (WB_CYCo && WB_STBo) begin
                slv_cnt++;
                if (ack_tied || slv_cnt >= ack_delay) begin
                    WB_ACKi = 1'b1;
                    WB_DATi = slave_mem[WB_ADRo];
                    if (WB_WEo) slave_mem[WB_ADRo] = WB_DATo;
                end else begin
                    WB_ACKi = 1'b0;
                    WB_DATi = 8'($urandom);
                end
            end else begin
                slv_cnt = 0;
                WB_ACKi = ack_tied ? 1'b1 : 1'($urandom);
                WB_DATi = 8'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a response or a
    // Wishbone cycle.
    bit   prev_cyc = 1'b0;
    int   run_len = 0;
    txn_t mon_cur;
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cyc = 1'b0;
                run_len  = 0;
            end else begin
                if (rsp_valid) begin
                    n_rsp++;
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        t = rsp_q.pop_front();
                        chk("rsp_dat", 32'(rsp_dat), 32'(t.rdat));
                        chk("rsp_err", 32'(rsp_err), 32'(t.err));
                        chk("rsp_cycle", cyc_num, t.rsp_cyc);
                    end
                end
                if (WB_CYCo) begin
                    if (!prev_cyc) begin
                        n_wb++;
                        run_len = 1;
                        if (wb_q.size() == 0) begin
                            chk("wb_unexpected", 32'd1, 32'd0);
                        end else begin
                            mon_cur = wb_q.pop_front();
                        end
                    end else begin
                        run_len++;
                    end
                    chk("wb_adr", 32'(WB_ADRo), 32'(mon_cur.adr));
                    chk("wb_we", 32'(WB_WEo), 32'(mon_cur.we));
                    if (mon_cur.we) chk("wb_dato", 32'(WB_DATo), 32'(mon_cur.dat));
                    chk("wb_stb", 32'(WB_STBo), 32'd1);
                end else begin
                    if (prev_cyc) chk("bus_len", run_len, mon_cur.bus_len);
                    chk("we_idle", 32'(WB_WEo), 32'd0);
                    chk("stb_idle", 32'(WB_STBo), 32'd0);
                end
                prev_cyc = WB_CYCo;
            end
        end
    end

    // Issue one command; called and returns away from the clock edge.
    // The expected result is computed from the reference memory model.
    task automatic send(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input int delay, output int acc);
        int   budget;
        int   eff;
        txn_t t;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        budget    = 0;
        acc       = -1;
        while (!cmd_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            ack_delay = delay;
            acc = cyc_num + 1;
            eff = ack_tied ? 1 : ((delay < 1) ? 1 : delay);
            t.we  = we;
            t.adr = adr;
            t.dat = dat;
            if (TO_EN && eff > int'(TO)) begin
                t.err     = 1'b1;
                t.rdat    = 8'h00;
                t.bus_len = int'(TO);
            end else begin
                t.err     = 1'b0;
                t.rdat    = we ? 8'h00 : model_mem[adr];
                t.bus_len = eff;
                if (we) model_mem[adr] = dat;
            end
            t.rsp_cyc = acc + t.bus_len;
            rsp_q.push_back(t);
            wb_q.push_back(t);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((rsp_q.size() != 0 || wb_q.size() != 0) && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("drain", rsp_q.size() + wb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int acc, prev_acc, r0, w0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_adr = 2'd0;
        cmd_dat = 8'h00;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 8'($urandom);
            slave_mem[i] = model_mem[i];
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat), 32'h00);
        chk("rst_cyc", 32'(WB_CYCo), 32'd0);
        chk("rst_stb", 32'(WB_STBo), 32'd0);
        chk("rst_we", 32'(WB_WEo), 32'd0);
        chk("rst_adr", 32'(WB_ADRo), 32'd0);
        chk("rst_dato", 32'(WB_DATo), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write with ACK tied high
        ack_tied = 1'b1;
        send(1'b1, 2'h1, 8'h5A, 1, acc);
        cmd_valid = 1'b0;
        drain();

        // Read with a 3-cycle ACK delay
        ack_tied = 1'b0;
        model_mem[2] = 8'hC3;
        slave_mem[2] = 8'hC3;
        send(1'b0, 2'h2, 8'h00, 3, acc);
        cmd_valid = 1'b0;
        drain();

        // Back-to-back commands with cmd_valid held high
        ack_tied = 1'b1;
        r0 = n_rsp;
        w0 = n_wb;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            send(1'($urandom), 2'(k), 8'($urandom), 1, acc);
            if (k > 0) chk("b2b_spacing", acc - prev_acc, 3);
            prev_acc = acc;
        end
        cmd_valid = 1'b0;
        drain();
        chk("b2b_rsp_count", n_rsp - r0, 4);
        chk("b2b_wb_count", n_wb - w0, 4);

        // ACK on the threshold cycle, then a slave that answers late
        ack_tied = 1'b0;
        send(1'b0, 2'h3, 8'h00, 4, acc);
        cmd_valid = 1'b0;
        drain();
        send(1'b1, 2'h3, 8'hA7, 9, acc);
        cmd_valid = 1'b0;
        drain();
        send(1'b0, 2'h3, 8'h00, 9, acc);
        cmd_valid = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            send(1'($urandom), 2'($urandom), 8'($urandom), $urandom_range(1, 6), acc);
            if ($urandom_range(0, 1) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        drain();

        // Reset two cycles into BUS aborts the cycle with no response
        ack_tied = 1'b0;
        send(1'b0, 2'h1, 8'h00, 20, acc);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_cyc", 32'(WB_CYCo), 32'd0);
        chk("abort_stb", 32'(WB_STBo), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        rsp_q.delete();
        wb_q.delete();
        r0 = n_rsp;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 32'(cmd_ready), 32'd1);
        ack_tied = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_rsp", n_rsp - r0, 0);

        // Traffic resumes normally after the abort
        send(1'b0, 2'h0, 8'h00, 1, acc);
        cmd_valid = 1'b0;
        drain();

        chk("final_queues", rsp_q.size() + wb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
